// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART transmitter and receiver.
//   - rx_state_t      : receiver FSM states (IDLE/START/DATA/STOP)
//   - START_BIT       : line level of the start bit (0)
//   - STOP_BIT        : line level of the stop bit (1)
//   - IDLE_LEVEL      : line level while no frame is in flight (1)
//   - even_parity_err : 1 when a word (data + parity bit) holds an odd number of ones
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // The word is zero-extended to 32 bits by the caller. Zero padding does not
    // change the XOR, so any frame up to 32 bits can be checked with this one function.
    function automatic logic even_parity_err(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2
//   Two-flop synchroniser for a single asynchronous input.
//   Ports:
//     clk   : input  1  sampling clock
//     reset : input  1  synchronous, active-high; loads RESET_VALUE into both flops
//     d     : input  1  asynchronous input
//     q     : output 1  synchronised copy of d (two clk latency)
//   Parameter:
//     RESET_VALUE : level both flops take in reset (the line's idle level)
module uart_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx_uart.sv
// rx_uart
//   Oversampling UART receiver. The frame is: start (0), data LSB first,
//   optional even-parity bit, one stop (1).
//   Ports:
//     clk          : input  1    single clock, posedge
//     reset        : input  1    synchronous, active-high
//     sample_tick  : input  1    one-clk strobe at OVERSAMPLE x baud
//     serial_in    : input  1    asynchronous serial line, idles high
//     o_data       : output N    received word, parity bit in MSB when enabled
//     o_valid      : output 1    one-clk pulse when o_data updates
//     o_parity_err : output 1    parity mismatch, qualified by o_valid
//     o_frame_err  : output 1    stop bit sampled low, qualified by o_valid
//     o_busy       : output 1    high from start detection until frame completion
//   N = INPUT_DATA_WIDTH + PARITY_ENABLED. OVERSAMPLE must be even and >= 4.
module rx_uart
    import uart_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int OVERSAMPLE       = 16
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       sample_tick,
    input  logic                                       serial_in,
    output logic [INPUT_DATA_WIDTH+PARITY_ENABLED-1:0] o_data,
    output logic                                       o_valid,
    output logic                                       o_parity_err,
    output logic                                       o_frame_err,
    output logic                                       o_busy
);

    localparam int N      = INPUT_DATA_WIDTH + PARITY_ENABLED;
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(N + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    // The detection tick already counts as the first tick of the start bit,
    // so mid-start is reached after OVERSAMPLE/2-1 further ticks.
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N - 1);

    logic rx_s;

    rx_state_t         state, state_n;
    logic [TICK_W-1:0] tick_cnt, tick_n;
    logic [BIT_W-1:0]  bit_cnt, bit_n;
    logic [N-1:0]      shift_reg, shift_n;
    logic              stop_sample, stop_n;
    logic              deliver, deliver_n;
    logic [N-1:0]      data_n;
    logic              valid_n, perr_n, ferr_n, busy_n;

    uart_sync2 #(
        .RESET_VALUE(IDLE_LEVEL)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (serial_in),
        .q    (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            stop_sample  <= STOP_BIT;
            deliver      <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= state_n;
            tick_cnt     <= tick_n;
            bit_cnt      <= bit_n;
            shift_reg    <= shift_n;
            stop_sample  <= stop_n;
            deliver      <= deliver_n;
            o_data       <= data_n;
            o_valid      <= valid_n;
            o_parity_err <= perr_n;
            o_frame_err  <= ferr_n;
            o_busy       <= busy_n;
        end
    end

    // The stop bit is sampled on the mid-stop tick and the FSM returns to IDLE
    // there, so the next start edge can be caught at once. The word is
    // published one clk later through the deliver flag. A start detected in
    // that same clk wins the o_busy update because the case statement comes last.
    always_comb begin
        state_n   = state;
        tick_n    = tick_cnt;
        bit_n     = bit_cnt;
        shift_n   = shift_reg;
        stop_n    = stop_sample;
        deliver_n = 1'b0;
        data_n    = o_data;
        valid_n   = 1'b0;
        perr_n    = o_parity_err;
        ferr_n    = o_frame_err;
        busy_n    = o_busy;

        if (deliver) begin
            data_n  = shift_reg;
            valid_n = 1'b1;
            ferr_n  = (stop_sample != STOP_BIT);
            perr_n  = (PARITY_ENABLED != 0) ? even_parity_err(32'(shift_reg)) : 1'b0;
            busy_n  = 1'b0;
        end

        case (state)
            IDLE: begin
                if (sample_tick && rx_s == START_BIT) begin
                    state_n = START;
                    tick_n  = '0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (tick_cnt == TICK_MID) begin
                        tick_n = '0;
                        if (rx_s == START_BIT) begin
                            state_n = DATA;
                            bit_n   = '0;
                        end else begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        // New bits enter at the MSB, so the first bit ends in bit 0.
                        shift_n = (shift_reg >> 1) | (N'(rx_s) << (N - 1));
                        bit_n   = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state_n = STOP;
                            bit_n   = '0;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (sample_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n    = '0;
                        stop_n    = rx_s;
                        deliver_n = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rx_uart.sv
// tb_rx_uart
//   Directed bench for rx_uart with 8 data bits, parity enabled and
//   OVERSAMPLE = 16. sample_tick fires every 4 clks, so one bit is 64 clks.
//   A monitor queues every o_valid pulse. Each test task drives its frames
//   and compares the captured words against hand-computed values.
module tb_rx_uart;

    localparam int W              = 8;
    localparam int P              = 1;
    localparam int OS             = 16;
    localparam int N              = W + P;
    localparam int CLKS_PER_TICK  = 4;
    localparam int BIT_CLKS       = OS * CLKS_PER_TICK;

    logic         clk = 1'b0;
    logic         reset;
    logic         sample_tick = 1'b0;
    logic         serial_in;
    logic [N-1:0] o_data;
    logic         o_valid;
    logic         o_parity_err;
    logic         o_frame_err;
    logic         o_busy;

    logic [N-1:0] cap_data[$];
    logic         cap_perr[$];
    logic         cap_ferr[$];

    int   checks = 0;
    int   passed = 0;
    int   tick_div = 0;
    logic busy_gap;

    rx_uart #(
        .INPUT_DATA_WIDTH(W),
        .PARITY_ENABLED  (P),
        .OVERSAMPLE      (OS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .serial_in   (serial_in),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_parity_err(o_parity_err),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    // Free-running tick strobe, one clk wide, every CLKS_PER_TICK clks.
    always @(negedge clk) begin
        tick_div    = (tick_div + 1) % CLKS_PER_TICK;
        sample_tick = (tick_div == 0);
    end

    // Capture every delivered word so that the tasks can inspect the pulse count and contents.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            cap_data.push_back(o_data);
            cap_perr.push_back(o_parity_err);
            cap_ferr.push_back(o_frame_err);
        end
    end

    task automatic clear_capture();
        cap_data.delete();
        cap_perr.delete();
        cap_ferr.delete();
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame. o_busy is looked at in the middle of each bit to see
    // that it stays high for the whole frame.
    task automatic send_frame(input logic [N-1:0] word, input logic stop_val, input int stop_clks);
        busy_gap  = 1'b0;
        serial_in = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        if (o_busy !== 1'b1) busy_gap = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            serial_in = word[i];
            repeat (BIT_CLKS / 2) @(negedge clk);
            if (o_busy !== 1'b1) busy_gap = 1'b1;
            repeat (BIT_CLKS / 2) @(negedge clk);
        end
        serial_in = stop_val;
        repeat (16) @(negedge clk);
        if (o_busy !== 1'b1) busy_gap = 1'b1;
        repeat (stop_clks - 16) @(negedge clk);
        serial_in = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (o_data !== '0) $display("[TB] FAIL reset_data got %h want 000", o_data); else passed++;
        checks++; if (o_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", o_valid); else passed++;
        checks++; if (o_parity_err !== 1'b0) $display("[TB] FAIL reset_perr got %b want 0", o_parity_err); else passed++;
        checks++; if (o_frame_err !== 1'b0) $display("[TB] FAIL reset_ferr got %b want 0", o_frame_err); else passed++;
        checks++; if (o_busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", o_busy); else passed++;
        reset = 1'b0;
        idle(20);
    endtask

    task automatic test_basic();
        clear_capture();
        send_frame(9'h0A5, 1'b1, BIT_CLKS);
        idle(BIT_CLKS);
        checks++; if (cap_data.size() != 1) $display("[TB] FAIL basic_count got %0d want 1", cap_data.size()); else passed++;
        checks++; if (cap_data.size() < 1 || cap_data[0] !== 9'h0A5) $display("[TB] FAIL basic_data got %h want 0a5", o_data); else passed++;
        checks++; if (cap_perr.size() < 1 || cap_perr[0] !== 1'b0) $display("[TB] FAIL basic_perr got %b want 0", o_parity_err); else passed++;
        checks++; if (cap_ferr.size() < 1 || cap_ferr[0] !== 1'b0) $display("[TB] FAIL basic_ferr got %b want 0", o_frame_err); else passed++;
        checks++; if (busy_gap !== 1'b0) $display("[TB] FAIL basic_busy_frame got gap=%b want 0", busy_gap); else passed++;
        checks++; if (o_busy !== 1'b0) $display("[TB] FAIL basic_busy_after got %b want 0", o_busy); else passed++;
    endtask

    task automatic test_glitch();
        clear_capture();
        serial_in = 1'b0;
        repeat (4 * CLKS_PER_TICK) @(negedge clk);
        checks++; if (o_busy !== 1'b1) $display("[TB] FAIL glitch_busy_seen got %b want 1", o_busy); else passed++;
        serial_in = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        checks++; if (cap_data.size() != 0) $display("[TB] FAIL glitch_count got %0d want 0", cap_data.size()); else passed++;
        checks++; if (o_busy !== 1'b0) $display("[TB] FAIL glitch_busy_after got %b want 0", o_busy); else passed++;
        checks++; if (o_data !== 9'h0A5) $display("[TB] FAIL glitch_data_hold got %h want 0a5", o_data); else passed++;
    endtask

    task automatic test_parity_err();
        clear_capture();
        send_frame(9'h13C, 1'b1, BIT_CLKS);
        idle(BIT_CLKS);
        checks++; if (cap_data.size() != 1) $display("[TB] FAIL perr_count got %0d want 1", cap_data.size()); else passed++;
        checks++; if (cap_data.size() < 1 || cap_data[0] !== 9'h13C) $display("[TB] FAIL perr_data got %h want 13c", o_data); else passed++;
        checks++; if (cap_perr.size() < 1 || cap_perr[0] !== 1'b1) $display("[TB] FAIL perr_flag got %b want 1", o_parity_err); else passed++;
        checks++; if (cap_ferr.size() < 1 || cap_ferr[0] !== 1'b0) $display("[TB] FAIL perr_ferr got %b want 0", o_frame_err); else passed++;
        checks++; if (o_parity_err !== 1'b1) $display("[TB] FAIL perr_hold got %b want 1", o_parity_err); else passed++;
    endtask

    // The stop bit is held low for 40 clks only. The receiver retriggers on
    // the low line after mid-stop and then sees a glitch, so it delivers
    // exactly one frame.
    task automatic test_frame_err();
        clear_capture();
        send_frame(9'h0FF, 1'b0, 40);
        idle(2 * BIT_CLKS);
        checks++; if (cap_data.size() != 1) $display("[TB] FAIL ferr_count got %0d want 1", cap_data.size()); else passed++;
        checks++; if (cap_data.size() < 1 || cap_data[0] !== 9'h0FF) $display("[TB] FAIL ferr_data got %h want 0ff", o_data); else passed++;
        checks++; if (cap_ferr.size() < 1 || cap_ferr[0] !== 1'b1) $display("[TB] FAIL ferr_flag got %b want 1", o_frame_err); else passed++;
        checks++; if (cap_perr.size() < 1 || cap_perr[0] !== 1'b0) $display("[TB] FAIL ferr_perr got %b want 0", o_parity_err); else passed++;
        checks++; if (o_busy !== 1'b0) $display("[TB] FAIL ferr_busy_after got %b want 0", o_busy); else passed++;
    endtask

    task automatic test_back_to_back();
        clear_capture();
        send_frame(9'h101, 1'b1, BIT_CLKS);
        send_frame(9'h180, 1'b1, BIT_CLKS);
        idle(BIT_CLKS);
        checks++; if (cap_data.size() != 2) $display("[TB] FAIL b2b_count got %0d want 2", cap_data.size()); else passed++;
        checks++; if (cap_data.size() < 1 || cap_data[0] !== 9'h101) $display("[TB] FAIL b2b_data0 got %h want 101", (cap_data.size() > 0) ? cap_data[0] : 9'h000); else passed++;
        checks++; if (cap_data.size() < 2 || cap_data[1] !== 9'h180) $display("[TB] FAIL b2b_data1 got %h want 180", (cap_data.size() > 1) ? cap_data[1] : 9'h000); else passed++;
        checks++; if (cap_perr.size() < 2 || cap_perr[0] !== 1'b0 || cap_perr[1] !== 1'b0) $display("[TB] FAIL b2b_perr got %b want 0", o_parity_err); else passed++;
        checks++; if (cap_ferr.size() < 2 || cap_ferr[0] !== 1'b0 || cap_ferr[1] !== 1'b0) $display("[TB] FAIL b2b_ferr got %b want 0", o_frame_err); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        logic [N-1:0] word;
        word = 9'h0B7;
        clear_capture();
        serial_in = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            serial_in = word[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        serial_in = word[3];
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset     = 1'b1;
        serial_in = 1'b1;
        @(negedge clk);
        checks++; if (o_data !== '0) $display("[TB] FAIL midrst_data got %h want 000", o_data); else passed++;
        checks++; if (o_busy !== 1'b0) $display("[TB] FAIL midrst_busy got %b want 0", o_busy); else passed++;
        checks++; if (o_valid !== 1'b0 || o_parity_err !== 1'b0 || o_frame_err !== 1'b0) $display("[TB] FAIL midrst_flags got %b%b%b want 000", o_valid, o_parity_err, o_frame_err); else passed++;
        reset = 1'b0;
        idle(12 * BIT_CLKS);
        checks++; if (cap_data.size() != 0) $display("[TB] FAIL midrst_count got %0d want 0", cap_data.size()); else passed++;
        send_frame(9'h055, 1'b1, BIT_CLKS);
        idle(BIT_CLKS);
        checks++; if (cap_data.size() != 1) $display("[TB] FAIL after_rst_count got %0d want 1", cap_data.size()); else passed++;
        checks++; if (cap_data.size() < 1 || cap_data[0] !== 9'h055) $display("[TB] FAIL after_rst_data got %h want 055", o_data); else passed++;
        checks++; if (cap_perr.size() < 1 || cap_perr[0] !== 1'b0 || cap_ferr[0] !== 1'b0) $display("[TB] FAIL after_rst_err got %b%b want 00", o_parity_err, o_frame_err); else passed++;
    endtask

    initial begin
        reset     = 1'b1;
        serial_in = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_parity_err();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
